user_io_mmio: RTL and testbench

- Memory-mapped I/O slave sitting directly downstream of the Riscv151 memory stage, on the 0x8xxx_xxxx address region.
- Serves the performance counters (cycles, retired instructions, counter reset), the button event FIFO, the switches and the LED register.
- Returns registered read data to the CPU writeback mux.
- UART addresses 0x8000_0000 to 0x8000_000C belong to the UART block; this block ignores them (hit = 0).

---
 rtl/mmio_pkg.sv | 18 +
 rtl/user_io_mmio_button_fifo.sv | 60 ++++++
 rtl/user_io_mmio.sv | 142 ++++++++++++++
 tb/tb_user_io_mmio.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Purpose: address map shared by the user I/O MMIO slave and anything decoding its region.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: MMIO_BASE region base plus word addresses of every register in the block.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;

  // 0x8000_0000..0x8000_000C belong to the UART and are deliberately absent here.
  localparam logic [31:0] MMIO_CYCLE_CNT  = MMIO_BASE + 32'h10;
  localparam logic [31:0] MMIO_INST_CNT   = MMIO_BASE + 32'h14;
  localparam logic [31:0] MMIO_CNT_RST    = MMIO_BASE + 32'h18;
  localparam logic [31:0] MMIO_FIFO_EMPTY = MMIO_BASE + 32'h20;
  localparam logic [31:0] MMIO_FIFO_DATA  = MMIO_BASE + 32'h24;
  localparam logic [31:0] MMIO_SWITCHES   = MMIO_BASE + 32'h28;
  localparam logic [31:0] MMIO_LEDS       = MMIO_BASE + 32'h30;

endpackage

// File: rtl/user_io_mmio_button_fifo.sv
// Purpose: small synchronous FIFO holding button snapshots (module button_fifo).
// Latency: write visible at dout the cycle after the push edge; dout is combinational from the head.
// Backpressure: none upstream -- pushes while full are dropped unless a pop frees a slot that edge.
// Ports: clk, rst (async, active-high), wr_en/din push side, rd_en/dout pop side, full, empty.
module button_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  // A pop from an empty FIFO is ignored; a pop on a full FIFO frees the slot the push needs.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/user_io_mmio.sv
// Purpose: MMIO slave for perf counters, button event FIFO, switches and LEDs in the 0x8xxx_xxxx region.
// Latency: loads return 1 cycle later in mmio_rdata/mmio_hit (pre-edge state), held until the next load.
// Backpressure: none -- every request is serviced in its cycle; button pushes are dropped while full.
// Ports: clk, rst; mmio_addr/re/we/wbe/wdata request; inst_retire, clean_buttons, switches inputs;
//        mmio_rdata, mmio_hit, leds outputs.
module user_io_mmio
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int N_BUTTONS  = 3,
  parameter int N_SWITCHES = 2,
  parameter int N_LEDS     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mmio_addr,
  input  logic                  mmio_re,
  input  logic                  mmio_we,
  input  logic [3:0]            mmio_wbe,
  input  logic [31:0]           mmio_wdata,
  input  logic                  inst_retire,
  input  logic [N_BUTTONS-1:0]  clean_buttons,
  input  logic [N_SWITCHES-1:0] switches,
  output logic [31:0]           mmio_rdata,
  output logic                  mmio_hit,
  output logic [N_LEDS-1:0]     leds
);

  logic [31:0]          cycle_cnt;
  logic [31:0]          inst_cnt;
  logic [N_BUTTONS-1:0] btn_q;
  logic [31:0]          word_addr;
  logic                 store_en;
  logic                 cnt_clr;
  logic                 led_wr;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [N_BUTTONS-1:0] fifo_dout;
  logic [31:0]          rd_val;
  logic                 rd_hit;
  logic                 unused_ok;

  assign word_addr = {mmio_addr[31:2], 2'b00};
  assign store_en  = mmio_we && (mmio_wbe != 4'b0000);
  assign cnt_clr   = store_en && (word_addr == MMIO_CNT_RST);
  assign led_wr    = store_en && (word_addr == MMIO_LEDS);
  // One push per rising edge of any button, so a held button is only recorded once.
  assign fifo_push = |(clean_buttons & ~btn_q);
  assign fifo_pop  = mmio_re && (word_addr == MMIO_FIFO_DATA);

  assign unused_ok = &{1'b0, fifo_full, mmio_addr[1:0], mmio_wdata[31:N_LEDS]};

  button_fifo #(
    .WIDTH (N_BUTTONS),
    .DEPTH (FIFO_DEPTH)
  ) u_button_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_push),
    .din   (clean_buttons),
    .full  (fifo_full),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    case (word_addr)
      MMIO_CYCLE_CNT: begin
        rd_val = cycle_cnt;
        rd_hit = 1'b1;
      end
      MMIO_INST_CNT: begin
        rd_val = inst_cnt;
        rd_hit = 1'b1;
      end
      MMIO_FIFO_EMPTY: begin
        rd_val[0] = fifo_empty;
        rd_hit    = 1'b1;
      end
      MMIO_FIFO_DATA: begin
        // Stale head contents must not leak out when nothing is queued.
        if (!fifo_empty) begin
          rd_val[N_BUTTONS-1:0] = fifo_dout;
        end
        rd_hit = 1'b1;
      end
      MMIO_SWITCHES: begin
        rd_val[N_SWITCHES-1:0] = switches;
        rd_hit                 = 1'b1;
      end
      MMIO_LEDS: begin
        rd_val[N_LEDS-1:0] = leds;
        rd_hit             = 1'b1;
      end
      default: begin
        rd_val = '0;
        rd_hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (cnt_clr) begin
      // Clear wins over the increment of the same cycle.
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_retire) begin
        inst_cnt <= inst_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= '0;
      leds       <= '0;
      mmio_rdata <= '0;
      mmio_hit   <= 1'b0;
    end else begin
      btn_q <= clean_buttons;
      if (led_wr) begin
        leds <= mmio_wdata[N_LEDS-1:0];
      end
      // Read data holds between loads so the writeback mux can sample it late.
      if (mmio_re) begin
        mmio_rdata <= rd_val;
        mmio_hit   <= rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_user_io_mmio.sv
module tb_user_io_mmio;

  localparam int DEPTH = 8;
  localparam int NB    = 3;
  localparam int NS    = 2;
  localparam int NL    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   mmio_addr = '0;
  logic          mmio_re = 1'b0;
  logic          mmio_we = 1'b0;
  logic [3:0]    mmio_wbe = '0;
  logic [31:0]   mmio_wdata = '0;
  logic          inst_retire = 1'b0;
  logic [NB-1:0] clean_buttons = '0;
  logic [NS-1:0] switches = '0;
  logic [31:0]   mmio_rdata;
  logic          mmio_hit;
  logic [NL-1:0] leds;

  int total = 0;
  int bad   = 0;

  user_io_mmio #(
    .FIFO_DEPTH (DEPTH),
    .N_BUTTONS  (NB),
    .N_SWITCHES (NS),
    .N_LEDS     (NL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_addr     (mmio_addr),
    .mmio_re       (mmio_re),
    .mmio_we       (mmio_we),
    .mmio_wbe      (mmio_wbe),
    .mmio_wdata    (mmio_wdata),
    .inst_retire   (inst_retire),
    .clean_buttons (clean_buttons),
    .switches      (switches),
    .mmio_rdata    (mmio_rdata),
    .mmio_hit      (mmio_hit),
    .leds          (leds)
  );

  always #5 clk = ~clk;

  // Behavioural reference: counters as integers, FIFO as a queue.
  int unsigned   m_cyc = 0;
  int unsigned   m_inst = 0;
  logic [NB-1:0] m_q[$];
  logic [NB-1:0] m_prev = '0;
  logic [NL-1:0] m_leds = '0;
  logic [31:0]   m_rdata = '0;
  logic          m_hit = 1'b0;
  logic [31:0]   mw;
  bit            m_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_inst = 0; m_q.delete(); m_prev = '0;
      m_leds = '0; m_rdata = '0; m_hit = 1'b0;
    end else begin
      mw = {mmio_addr[31:2], 2'b00};
      if (mmio_re) begin
        m_hit = 1'b1;
        if (mw == 32'h8000_0010)      m_rdata = m_cyc;
        else if (mw == 32'h8000_0014) m_rdata = m_inst;
        else if (mw == 32'h8000_0020) m_rdata = (m_q.size() == 0) ? 32'd1 : 32'd0;
        else if (mw == 32'h8000_0024) m_rdata = (m_q.size() == 0) ? 32'd0 : 32'(m_q[0]);
        else if (mw == 32'h8000_0028) m_rdata = 32'(switches);
        else if (mw == 32'h8000_0030) m_rdata = 32'(m_leds);
        else begin m_rdata = 32'd0; m_hit = 1'b0; end
      end
      m_clr  = mmio_we && (mmio_wbe != 0) && (mw == 32'h8000_0018);
      m_cyc  = m_clr ? 0 : m_cyc + 1;
      m_inst = m_clr ? 0 : m_inst + (inst_retire ? 1 : 0);
      if (mmio_re && mw == 32'h8000_0024 && m_q.size() > 0) void'(m_q.pop_front());
      if (|(clean_buttons & ~m_prev) && m_q.size() < DEPTH) m_q.push_back(clean_buttons);
      m_prev = clean_buttons;
      if (mmio_we && (mmio_wbe != 0) && mw == 32'h8000_0030) m_leds = mmio_wdata[NL-1:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_rdata", mmio_rdata, m_rdata);
      check("model_hit", 32'(mmio_hit), 32'(m_hit));
      check("model_leds", 32'(leds), 32'(m_leds));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    mmio_addr = a; mmio_re = 1'b1;
    tick();
    mmio_re = 1'b0;
    d = mmio_rdata; h = mmio_hit;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] be);
    mmio_addr = a; mmio_we = 1'b1; mmio_wdata = dat; mmio_wbe = be;
    tick();
    mmio_we = 1'b0; mmio_wbe = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    logic [31:0] d;
    logic        h;
    rd(a, d, h);
    check(name, d, exp);
    check({name, "_hit"}, 32'(h), 32'(exp_hit));
  endtask

  logic [NB-1:0] pats[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
  logic [NB-1:0] drain[8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd4};
  logic [31:0]   amap[11] = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_0020,
                              32'h8000_0024, 32'h8000_0028, 32'h8000_0030, 32'h8000_0040,
                              32'h8000_0000, 32'h8000_000C, 32'h0000_0010};

  initial begin
    // Reset state
    tick();
    check("rst_rdata", mmio_rdata, 32'd0);
    check("rst_hit", 32'(mmio_hit), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Cycle counter and initial empty flag
    repeat (5) tick();
    rd_chk("cycle_at_5", 32'h8000_0010, 32'd5, 1'b1);
    rd_chk("empty_after_rst", 32'h8000_0020, 32'd1, 1'b1);

    // Instruction counter and clear-overrides-increment
    inst_retire = 1'b1;
    repeat (22) tick();
    inst_retire = 1'b0;
    rd_chk("inst_22", 32'h8000_0014, 32'd22, 1'b1);
    inst_retire = 1'b1;
    wr(32'h8000_0018, 32'hDEAD_BEEF, 4'h1);
    inst_retire = 1'b0;
    rd_chk("cycle_cleared", 32'h8000_0010, 32'd0, 1'b1);
    rd_chk("inst_cleared", 32'h8000_0014, 32'd0, 1'b1);

    // Held buttons give exactly one push
    clean_buttons = 3'b111;
    repeat (20) tick();
    rd_chk("held_not_empty", 32'h8000_0020, 32'd0, 1'b1);
    rd_chk("held_pop", 32'h8000_0024, 32'd7, 1'b1);
    rd_chk("held_empty", 32'h8000_0020, 32'd1, 1'b1);
    rd_chk("underflow_pop", 32'h8000_0024, 32'd0, 1'b1);
    rd_chk("still_empty", 32'h8000_0020, 32'd1, 1'b1);
    clean_buttons = '0;
    tick();

    // Ten edges into an eight-deep FIFO, then push+pop while full
    foreach (pats[i]) begin
      clean_buttons = pats[i]; tick();
      clean_buttons = '0;      tick();
    end
    clean_buttons = 3'd4;
    rd_chk("full_pushpop", 32'h8000_0024, 32'd1, 1'b1);
    clean_buttons = '0;
    foreach (drain[i]) rd_chk($sformatf("drain_%0d", i), 32'h8000_0024, 32'(drain[i]), 1'b1);
    rd_chk("drained_empty", 32'h8000_0020, 32'd1, 1'b1);

    // Switches and LEDs
    switches = 2'b11;
    tick();
    rd_chk("switches", 32'h8000_0028, 32'd3, 1'b1);
    wr(32'h8000_0030, 32'h0000_0011, 4'hF);
    check("leds_store", 32'(leds), 32'h11);
    wr(32'h8000_0030, 32'h0000_003F, 4'h0);
    check("leds_wbe0", 32'(leds), 32'h11);
    rd_chk("leds_read", 32'h8000_0030, 32'h11, 1'b1);
    rd_chk("unmapped", 32'h8000_0040, 32'd0, 1'b0);
    rd_chk("uart_ignored", 32'h8000_0004, 32'd0, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      mmio_addr   = amap[$urandom_range(0, 10)] | 32'($urandom_range(0, 3));
      mmio_re     = ($urandom_range(0, 2) == 0) && ({mmio_addr[31:2], 2'b00} != 32'h8000_0018);
      mmio_we     = ($urandom_range(0, 5) == 0);
      mmio_wbe    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      mmio_wdata  = $urandom;
      inst_retire = 1'($urandom);
      if ($urandom_range(0, 3) == 0) clean_buttons = NB'($urandom);
      if ($urandom_range(0, 15) == 0) switches = NS'($urandom);
      tick();
    end
    mmio_re = 1'b0; mmio_we = 1'b0; mmio_wbe = '0; inst_retire = 1'b0;

    // Asynchronous reset in the middle of filling the FIFO
    clean_buttons = '0; tick();
    clean_buttons = 3'd1; tick();
    clean_buttons = 3'd0; tick();
    clean_buttons = 3'd2;
    #3 rst = 1'b1;
    #1;
    check("arst_leds", 32'(leds), 32'd0);
    check("arst_rdata", mmio_rdata, 32'd0);
    check("arst_hit", 32'(mmio_hit), 32'd0);
    clean_buttons = '0;
    tick(); tick();
    rst = 1'b0;
    rd_chk("arst_cycle", 32'h8000_0010, 32'd0, 1'b1);
    rd_chk("arst_inst", 32'h8000_0014, 32'd0, 1'b1);
    rd_chk("arst_empty", 32'h8000_0020, 32'd1, 1'b1);
    rd_chk("arst_pop", 32'h8000_0024, 32'd0, 1'b1);
    check("arst_leds_after", 32'(leds), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
